// File: rtl/aes_dom_share_sequencer.sv
// Host-side share sequencer for the byte-serial DOM AES core: masks PT/key bytes, feeds randomness, recombines CT.
// Latency: accept -> CoreStart 1 cycle; last ciphertext byte -> OutValid 1 cycle; WAIT aborts after TIMEOUT cycles.
// Backpressure: InReady only in IDLE; result held stable in HOLD until OutReady, new jobs refused meanwhile.
module aes_dom_share_sequencer #(
    parameter int          N_SHARE   = 1,
    parameter logic [63:0] LFSR_SEED = 64'hACE1_2468_1357_BDF0,
    parameter int          TIMEOUT   = 1023
) (
    input  logic                     ClkxCI,
    input  logic                     RstxBI,
    input  logic                     InValidxSI,
    output logic                     InReadyxSO,
    input  logic [127:0]             PtxDI,
    input  logic [127:0]             KeyxDI,
    output logic                     OutValidxSO,
    input  logic                     OutReadyxSI,
    output logic [127:0]             CtxDO,
    output logic                     ErrxSO,
    input  logic                     ReseedxSI,
    input  logic [63:0]              SeedxDI,
    output logic                     CoreStartxSO,
    output logic [8*(N_SHARE+1)-1:0] CorePtxDO,
    output logic [8*(N_SHARE+1)-1:0] CoreKxDO,
    output logic [17:0]              CoreZxDO,
    output logic [19:0]              CoreBxDO,
    input  logic                     CoreDonexSI,
    input  logic [8*(N_SHARE+1)-1:0] CoreCxDI
);
    localparam int          WCW      = $clog2(TIMEOUT + 1);
    localparam logic [63:0] LFSR_TAP = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {
        Idle,
        Load,
        Wait,
        Unload,
        Hold
    } state_t;

    state_t            stateQ, stateD;
    logic [3:0]        byteCntQ, byteCntD;
    logic [WCW-1:0]    waitCntQ, waitCntD;
    logic [3:0]        byteIdx;
    logic              captureJob, captureCt, setErr;

    logic [15:0][7:0]  ptQ, keyQ, ctQ;
    logic              errQ;
    logic [63:0]       lfsrQ, lfsrNext;
    logic [17:0]       zQ;
    logic [19:0]       bQ;
    logic [7:0]        ptMaskQ, keyMaskQ;
    logic [7:0]        ctByte;

    // Packed byte 15 is the MSB, i.e. host byte 0.
    assign byteIdx = 4'd15 - byteCntQ;

    assign lfsrNext = {1'b0, lfsrQ[63:1]} ^ (lfsrQ[0] ? LFSR_TAP : 64'd0);

    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            stateQ   <= Idle;
            byteCntQ <= '0;
            waitCntQ <= '0;
        end else begin
            stateQ   <= stateD;
            byteCntQ <= byteCntD;
            waitCntQ <= waitCntD;
        end
    end

    always_comb begin
        stateD       = stateQ;
        byteCntD     = byteCntQ;
        waitCntD     = waitCntQ;
        InReadyxSO   = 1'b0;
        OutValidxSO  = 1'b0;
        CoreStartxSO = 1'b0;
        captureJob   = 1'b0;
        captureCt    = 1'b0;
        setErr       = 1'b0;
        unique case (stateQ)
            Idle: begin
                InReadyxSO = 1'b1;
                if (InValidxSI) begin
                    captureJob = 1'b1;
                    byteCntD   = '0;
                    stateD     = Load;
                end
            end
            Load: begin
                CoreStartxSO = (byteCntQ == 4'd0);
                byteCntD     = byteCntQ + 4'd1;
                if (byteCntQ == 4'd15) begin
                    waitCntD = '0;
                    stateD   = Wait;
                end
            end
            Wait: begin
                // Done wins over a coincident timeout: the result is already on the bus.
                if (CoreDonexSI) begin
                    captureCt = 1'b1;
                    byteCntD  = 4'd1;
                    stateD    = Unload;
                end else if (waitCntQ == WCW'(TIMEOUT)) begin
                    setErr = 1'b1;
                    stateD = Idle;
                end else begin
                    waitCntD = waitCntQ + WCW'(1);
                end
            end
            Unload: begin
                captureCt = 1'b1;
                byteCntD  = byteCntQ + 4'd1;
                if (byteCntQ == 4'd15) begin
                    stateD = Hold;
                end
            end
            Hold: begin
                OutValidxSO = 1'b1;
                if (OutReadyxSI) begin
                    stateD = Idle;
                end
            end
            default: stateD = Idle;
        endcase
    end

    // All shares of one byte are folded in the same cycle they arrive.
    always_comb begin
        ctByte = '0;
        for (int s = 0; s <= N_SHARE; s++) begin
            ctByte = ctByte ^ CoreCxDI[8*s +: 8];
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            lfsrQ    <= LFSR_SEED;
            zQ       <= '0;
            bQ       <= '0;
            ptMaskQ  <= '0;
            keyMaskQ <= '0;
            ptQ      <= '0;
            keyQ     <= '0;
            ctQ      <= '0;
            errQ     <= 1'b0;
        end else begin
            lfsrQ    <= (ReseedxSI && (SeedxDI != 64'd0)) ? SeedxDI : lfsrNext;
            zQ       <= lfsrQ[17:0];
            bQ       <= lfsrQ[37:18];
            ptMaskQ  <= lfsrQ[45:38];
            keyMaskQ <= lfsrQ[53:46];
            if (captureJob) begin
                ptQ  <= PtxDI;
                keyQ <= KeyxDI;
            end
            if (captureCt) begin
                ctQ[byteIdx] <= ctByte;
            end
            if (captureJob) begin
                errQ <= 1'b0;
            end else if (setErr) begin
                errQ <= 1'b1;
            end
        end
    end

    // Only first-order masking has randomness wired; higher shares stay zero.
    always_comb begin
        CorePtxDO = '0;
        CoreKxDO  = '0;
        if (stateQ == Load) begin
            CorePtxDO[15:8] = ptMaskQ;
            CorePtxDO[7:0]  = ptQ[byteIdx] ^ ptMaskQ;
            CoreKxDO[15:8]  = keyMaskQ;
            CoreKxDO[7:0]   = keyQ[byteIdx] ^ keyMaskQ;
        end
    end

    assign CoreZxDO = zQ;
    assign CoreBxDO = bQ;
    assign CtxDO    = ctQ;
    assign ErrxSO   = errQ;

endmodule

// File: tb/tb_aes_dom_share_sequencer.sv
// Bench for aes_dom_share_sequencer: behavioural AES core, LFSR reference and host-side job driver.
module tb_aes_dom_share_sequencer;
    localparam int          TIMEOUT = 1023;
    localparam logic [63:0] SEED    = 64'hACE1_2468_1357_BDF0;

    logic         clk = 1'b0;
    logic         RstxBI = 1'b0;
    logic         InValidxSI = 1'b0;
    logic         InReadyxSO;
    logic [127:0] PtxDI = '0;
    logic [127:0] KeyxDI = '0;
    logic         OutValidxSO;
    logic         OutReadyxSI = 1'b0;
    logic [127:0] CtxDO;
    logic         ErrxSO;
    logic         ReseedxSI = 1'b0;
    logic [63:0]  SeedxDI = '0;
    logic         CoreStartxSO;
    logic [15:0]  CorePtxDO, CoreKxDO;
    logic [17:0]  CoreZxDO;
    logic [19:0]  CoreBxDO;
    logic         CoreDonexSI = 1'b0;
    logic [15:0]  CoreCxDI = '0;

    always #5 clk = ~clk;

    aes_dom_share_sequencer #(
        .N_SHARE  (1),
        .LFSR_SEED(SEED),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .ClkxCI      (clk),
        .RstxBI      (RstxBI),
        .InValidxSI  (InValidxSI),
        .InReadyxSO  (InReadyxSO),
        .PtxDI       (PtxDI),
        .KeyxDI      (KeyxDI),
        .OutValidxSO (OutValidxSO),
        .OutReadyxSI (OutReadyxSI),
        .CtxDO       (CtxDO),
        .ErrxSO      (ErrxSO),
        .ReseedxSI   (ReseedxSI),
        .SeedxDI     (SeedxDI),
        .CoreStartxSO(CoreStartxSO),
        .CorePtxDO   (CorePtxDO),
        .CoreKxDO    (CoreKxDO),
        .CoreZxDO    (CoreZxDO),
        .CoreBxDO    (CoreBxDO),
        .CoreDonexSI (CoreDonexSI),
        .CoreCxDI    (CoreCxDI)
    );

    int nChk = 0;
    int nFail = 0;
    int cyc = 0;
    logic [127:0] curPt, curKey;
    bit   coreMute = 0, coreBusy = 0, doneSeen = 0;
    int   doneCyc = 0, lastCyc = 0;
    logic [63:0] mLfsr;
    logic [17:0] expZ;
    logic [19:0] expB;
    logic [7:0]  expPm, expKm;
    logic [15:0] ldPt [16], ldK [16], svPt [16], svK [16];
    logic [17:0] ldZ [16], svZ [16];
    logic [19:0] ldB [16], svB [16];
    logic [7:0]  sbox [256];

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChk++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    initial begin
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [176];
        logic [7:0] tmp [4];
        logic [7:0] rc, x, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            w[i] = key[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                x = tmp[0];
                tmp[0] = sbox[tmp[1]] ^ rc;
                tmp[1] = sbox[tmp[2]];
                tmp[2] = sbox[tmp[3]];
                tmp[3] = sbox[x];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[q+4*c] = t[q+4*((c+q)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Galois step of x^64+x^63+x^61+x^60+1: term x^t feeds back into bit t-1.
    function automatic logic [63:0] lfsrStep(input logic [63:0] s);
        logic [63:0] poly;
        poly = '0;
        poly[63] = 1'b1;
        poly[62] = 1'b1;
        poly[60] = 1'b1;
        poly[59] = 1'b1;
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!RstxBI) begin
            mLfsr = SEED;
            expZ = '0; expB = '0; expPm = '0; expKm = '0;
        end else begin
            expZ  = mLfsr[17:0];
            expB  = mLfsr[37:18];
            expPm = mLfsr[45:38];
            expKm = mLfsr[53:46];
            mLfsr = (ReseedxSI && SeedxDI != 64'd0) ? SeedxDI : lfsrStep(mLfsr);
        end
    end

    always @(negedge clk) begin
        checkVal("coreZ", 128'(CoreZxDO), 128'(expZ));
        checkVal("coreB", 128'(CoreBxDO), 128'(expB));
    end

    // Behavioural core: collect 16 share pairs, encrypt, return masked CT after a random delay.
    initial begin
        logic [127:0] colPt, colKey, ct;
        logic [7:0]   pB, kB, m;
        forever begin
            @(negedge clk);
            if (RstxBI && CoreStartxSO) begin
                coreBusy = 1;
                for (int i = 0; i < 16; i++) begin
                    if (i > 0) @(negedge clk);
                    checkVal("loadStart", 128'(CoreStartxSO), 128'(i == 0));
                    pB = CorePtxDO[7:0] ^ CorePtxDO[15:8];
                    kB = CoreKxDO[7:0] ^ CoreKxDO[15:8];
                    checkVal("loadPtByte", 128'(pB), 128'(curPt[127-8*i -: 8]));
                    checkVal("loadKeyByte", 128'(kB), 128'(curKey[127-8*i -: 8]));
                    checkVal("ptMask", 128'(CorePtxDO[15:8]), 128'(expPm));
                    checkVal("keyMask", 128'(CoreKxDO[15:8]), 128'(expKm));
                    colPt[127-8*i -: 8]  = pB;
                    colKey[127-8*i -: 8] = kB;
                end
                if (!coreMute) begin
                    ct = aes128(colPt, colKey);
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                    for (int i = 0; i < 16; i++) begin
                        if (i > 0) @(negedge clk);
                        m = 8'($urandom);
                        CoreDonexSI = (i == 0);
                        CoreCxDI = {m, ct[127-8*i -: 8] ^ m};
                        if (i == 0) begin doneCyc = cyc; doneSeen = 1; end
                        if (i == 15) lastCyc = cyc;
                    end
                    @(negedge clk);
                    CoreDonexSI = 0;
                    CoreCxDI = 16'($urandom);
                end
                coreBusy = 0;
            end
        end
    end

    task automatic waitCoreIdle();
        int n;
        n = 0;
        while (coreBusy && n < 300) begin @(negedge clk); n++; end
        checkVal("coreIdle", 128'(coreBusy), 128'(0));
    endtask

    task automatic chkResetOuts(input string tag);
        checkVal({tag, "InReady"}, 128'(InReadyxSO), 128'(1));
        checkVal({tag, "OutValid"}, 128'(OutValidxSO), 128'(0));
        checkVal({tag, "Ct"}, CtxDO, 128'(0));
        checkVal({tag, "Err"}, 128'(ErrxSO), 128'(0));
        checkVal({tag, "Start"}, 128'(CoreStartxSO), 128'(0));
        checkVal({tag, "CorePt"}, 128'(CorePtxDO), 128'(0));
        checkVal({tag, "CoreK"}, 128'(CoreKxDO), 128'(0));
        checkVal({tag, "CoreZ"}, 128'(CoreZxDO), 128'(0));
        checkVal({tag, "CoreB"}, 128'(CoreBxDO), 128'(0));
    endtask

    task automatic startJob(input logic [127:0] pt, input logic [127:0] key, output int cs);
        waitCoreIdle();
        @(negedge clk);
        checkVal("inReady", 128'(InReadyxSO), 128'(1));
        curPt = pt; curKey = key;
        PtxDI = pt; KeyxDI = key; InValidxSI = 1;
        @(negedge clk);
        InValidxSI = 0;
        PtxDI = {$urandom, $urandom, $urandom, $urandom};
        KeyxDI = {$urandom, $urandom, $urandom, $urandom};
        cs = cyc;
        checkVal("startLat", 128'(CoreStartxSO), 128'(1));
        checkVal("errClr", 128'(ErrxSO), 128'(0));
        checkVal("busyReady", 128'(InReadyxSO), 128'(0));
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            ldPt[i] = CorePtxDO; ldK[i] = CoreKxDO; ldZ[i] = CoreZxDO; ldB[i] = CoreBxDO;
        end
    endtask

    task automatic runJob(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp, input int hold);
        int n, cs;
        startJob(pt, key, cs);
        n = 0;
        while (!OutValidxSO && n < 200) begin @(negedge clk); n++; end
        checkVal("outValid", 128'(OutValidxSO), 128'(1));
        checkVal("ct", CtxDO, exp);
        checkVal("validLat", 128'(cyc - lastCyc), 128'(1));
        checkVal("noErr", 128'(ErrxSO), 128'(0));
        InValidxSI = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (h == 0 || h == hold - 1) begin
                checkVal("holdValid", 128'(OutValidxSO), 128'(1));
                checkVal("holdCt", CtxDO, exp);
                checkVal("holdReady", 128'(InReadyxSO), 128'(0));
            end
        end
        InValidxSI = 0;
        OutReadyxSI = 1;
        @(negedge clk);
        OutReadyxSI = 0;
        checkVal("validDrop", 128'(OutValidxSO), 128'(0));
        checkVal("idleReady", 128'(InReadyxSO), 128'(1));
    endtask

    task automatic reseedOne();
        waitCoreIdle();
        @(negedge clk);
        ReseedxSI = 1; SeedxDI = 64'h1;
        @(negedge clk);
        ReseedxSI = 0; SeedxDI = {$urandom, $urandom};
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p, k;
        int cs, n, errCyc;
        bit sawValid;
        repeat (3) @(negedge clk);
        chkResetOuts("reset");
        RstxBI = 1;

        // Done while idle must not start an unload.
        @(negedge clk); CoreDonexSI = 1;
        @(negedge clk); CoreDonexSI = 0;
        checkVal("strayDoneReady", 128'(InReadyxSO), 128'(1));
        checkVal("strayDoneValid", 128'(OutValidxSO), 128'(0));

        runJob(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
        runJob(128'h0, 128'h0, aes128(128'h0, 128'h0), 3);
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        runJob(p, k, aes128(p, k), 50);
        for (int j = 0; j < 6; j++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            runJob(p, k, aes128(p, k), $urandom_range(0, 4));
        end

        // Identical jobs after identical reseeds give identical core streams.
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        reseedOne();
        runJob(p, k, aes128(p, k), 0);
        svPt = ldPt; svK = ldK; svZ = ldZ; svB = ldB;
        reseedOne();
        runJob(p, k, aes128(p, k), 2);
        for (int i = 0; i < 16; i++) begin
            checkVal("reseedPt", 128'(ldPt[i]), 128'(svPt[i]));
            checkVal("reseedK", 128'(ldK[i]), 128'(svK[i]));
            checkVal("reseedZ", 128'(ldZ[i]), 128'(svZ[i]));
            checkVal("reseedB", 128'(ldB[i]), 128'(svB[i]));
        end
        @(negedge clk);
        ReseedxSI = 1; SeedxDI = 64'h0;
        repeat (4) @(negedge clk);
        ReseedxSI = 0;

        // Core never answers.
        coreMute = 1;
        p = {$urandom, $urandom, $urandom, $urandom};
        startJob(p, p, cs);
        n = 0; sawValid = 0;
        while (!ErrxSO && n < TIMEOUT + 100) begin
            @(negedge clk); n++;
            if (OutValidxSO) sawValid = 1;
        end
        errCyc = cyc;
        checkVal("timeoutErr", 128'(ErrxSO), 128'(1));
        checkVal("timeoutWindow", 128'(errCyc >= cs + 16 + TIMEOUT && errCyc <= cs + 17 + TIMEOUT), 128'(1));
        checkVal("timeoutReady", 128'(InReadyxSO), 128'(1));
        checkVal("timeoutNoValid", 128'(sawValid), 128'(0));
        waitCoreIdle();
        coreMute = 0;
        repeat (5) @(negedge clk);
        checkVal("errSticky", 128'(ErrxSO), 128'(1));
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        runJob(p, k, aes128(p, k), 1);

        // Reset while the sequencer captures ciphertext byte 7.
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        doneSeen = 0;
        startJob(p, k, cs);
        n = 0;
        while (!doneSeen && n < 200) begin @(negedge clk); n++; end
        checkVal("coreDone", 128'(doneSeen), 128'(1));
        while (cyc < doneCyc + 7 && n < 400) begin @(negedge clk); n++; end
        RstxBI = 0;
        @(negedge clk);
        chkResetOuts("midReset");
        RstxBI = 1;
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        runJob(p, k, aes128(p, k), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
